// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared CPU package: divider state encoding and sizing
package div_iter_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract division step
// Ports:
//   rem_in  - partial remainder before the step
//   quo_in  - quotient/dividend shift register before the step
//   divisor - divisor magnitude
//   rem_out - partial remainder after the step
//   quo_out - quotient/dividend shift register after the step
module div_step
    import div_iter_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_in,
    input  logic [DIV_WIDTH-1:0] quo_in,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_out,
    output logic [DIV_WIDTH-1:0] quo_out
);

    logic [DIV_WIDTH:0] trial;
    logic [DIV_WIDTH:0] diff;
    logic               fits;

    // The next dividend bit shifts out of the top of quo_in into the remainder;
    // the freed low bit of quo_in receives the new quotient bit.
    assign trial   = {rem_in, quo_in[DIV_WIDTH-1]};
    assign diff    = trial - {1'b0, divisor};
    assign fits    = (trial >= {1'b0, divisor});
    assign rem_out = fits ? diff[DIV_WIDTH-1:0] : trial[DIV_WIDTH-1:0];
    assign quo_out = {quo_in[DIV_WIDTH-2:0], fits};

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative 32-step restoring divider (DIV/DIVU), hilo result
// Optional feature macro: DIV_FLUSH_EN (adds the flush abort port).
// Ports:
//   clk        - rising-edge clock
//   resetn     - asynchronous active-low reset
//   start      - division request, sampled only in IDLE
//   signed_div - 1 = signed, 0 = unsigned; sampled with start
//   a, b       - dividend and divisor; sampled with start
//   flush      - abort request (DIV_FLUSH_EN only)
//   busy       - high in CALC and DONE
//   valid      - one-cycle result strobe (DONE)
//   result     - {remainder, quotient}
module div_iter
    import div_iter_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   signed_div,
    input  logic [DIV_WIDTH-1:0]   a,
    input  logic [DIV_WIDTH-1:0]   b,
`ifdef DIV_FLUSH_EN
    input  logic                   flush,
`endif
    output logic                   busy,
    output logic                   valid,
    output logic [2*DIV_WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_ITERS - 1);

    div_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic [DIV_WIDTH-1:0] rem;
    logic [DIV_WIDTH-1:0] quo;
    logic [DIV_WIDTH-1:0] dvs;
    logic                 sign_a;
    logic                 sign_b;
    logic                 sdiv;
    logic                 b_zero;
    logic                 kill;

    logic [DIV_WIDTH-1:0] rem_next;
    logic [DIV_WIDTH-1:0] quo_next;
    logic [DIV_WIDTH-1:0] q_final;
    logic [DIV_WIDTH-1:0] r_final;

`ifdef DIV_FLUSH_EN
    assign kill  = flush;
    assign valid = (state == DONE) && !flush;
`else
    assign kill  = 1'b0;
    assign valid = (state == DONE);
`endif

    assign busy = (state != IDLE);

    div_step u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvs),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    // With a zero divisor every step "fits", so the remainder ends as |a| and
    // sign correction restores a itself; only the quotient must be forced.
    // The INT_MIN / -1 case falls out naturally: magnitude 0x80000000 negated
    // is still 0x80000000.
    always_comb begin
        q_final = quo_next;
        r_final = rem_next;
        if (b_zero) begin
            q_final = '1;
        end else if (sdiv && (sign_a ^ sign_b)) begin
            q_final = -quo_next;
        end
        if (sdiv && sign_a) begin
            r_final = -rem_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            sdiv   <= 1'b0;
            b_zero <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        sdiv   <= signed_div;
                        sign_a <= a[DIV_WIDTH-1];
                        sign_b <= b[DIV_WIDTH-1];
                        b_zero <= (b == '0);
                        quo    <= (signed_div && a[DIV_WIDTH-1]) ? -a : a;
                        dvs    <= (signed_div && b[DIV_WIDTH-1]) ? -b : b;
                        rem    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_STEP) begin
                            result <= {r_final, q_final};
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter against an arithmetic model
module tb_div_iter;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
`ifdef DIV_FLUSH_EN
    logic        flush;
`endif
    logic        busy;
    logic        valid;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;

    div_iter dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
`ifdef DIV_FLUSH_EN
        .flush      (flush),
`endif
        .busy       (busy),
        .valid      (valid),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic [31:0] q;
        logic [31:0] r;
        sx = x;
        sy = y;
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (sd) begin
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
            q = sx / sy;
            r = sx % sy;
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    // Launches one operation and watches 50 cycles: latency in cycles after the
    // acceptance edge of the first valid, the result then, and pulse count.
    task automatic run_op(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                          output logic [63:0] res, output int lat, output int pulses);
        @(negedge clk);
        start = 1'b1; signed_div = sd; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; signed_div = $urandom; a = $urandom; b = $urandom;
        lat = 0; pulses = 0; res = '0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    res = result;
                end
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; a = '0; b = '0;
`ifdef DIV_FLUSH_EN
        flush = 1'b0;
`endif
        #3;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b valid=%b result=%h expected 0/0/0", busy, valid, result);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_directed;
        logic        sds[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] as[6]   = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h12345678, 32'h12345678, 32'h80000000};
        logic [31:0] bs[6]   = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic [63:0] exps[6] = '{{32'd2, 32'd14}, {32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'hFFFFFFFD},
                                 {32'h12345678, 32'hFFFFFFFF}, {32'h12345678, 32'hFFFFFFFF},
                                 {32'd0, 32'h80000000}};
        logic [63:0] res;
        int lat, pulses;
        for (int i = 0; i < 6; i++) begin
            run_op(sds[i], as[i], bs[i], res, lat, pulses);
            checks++;
            if (res !== exps[i]) begin
                errors++;
                $display("FAIL directed_%0d result=%h expected %h", i, res, exps[i]);
            end
            checks++;
            if (lat != 33 || pulses != 1) begin
                errors++;
                $display("FAIL directed_lat_%0d latency=%0d pulses=%0d expected 33/1", i, lat, pulses);
            end
        end
    endtask

    task automatic test_random;
        logic [63:0] res;
        logic [63:0] exp_r;
        logic [31:0] av, bv;
        logic sd;
        int lat, pulses;
        for (int i = 0; i < 24; i++) begin
            sd = $urandom;
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 5))
                0: bv = 32'd0;
                1: bv = $urandom_range(1, 20);
                2: begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
                3: bv = -$urandom_range(1, 20);
                default: ;
            endcase
            exp_r = ref_div(sd, av, bv);
            run_op(sd, av, bv, res, lat, pulses);
            checks++;
            if (res !== exp_r || lat != 33 || pulses != 1) begin
                errors++;
                $display("FAIL random_%0d sd=%b a=%h b=%h result=%h lat=%0d pulses=%0d expected %h lat 33 pulses 1",
                         i, sd, av, bv, res, lat, pulses, exp_r);
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [63:0] res;
        int lat, pulses;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; pulses = 0; res = '0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1; signed_div = 1'b1; a = 32'd50; b = 32'd3;
            end else if (k == 6) begin
                start = 1'b0;
            end
            if (valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    res = result;
                end
            end
        end
        checks++;
        if (res !== {32'd2, 32'd14} || pulses != 1 || lat != 33) begin
            errors++;
            $display("FAIL start_ignored result=%h pulses=%0d lat=%0d expected %h 1 33", res, pulses, lat, {32'd2, 32'd14});
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] res;
        int lat, pulses;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b valid=%b result=%h expected 0/0/0", busy, valid, result);
        end
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_valid pulses=%0d busy=%b expected 0/0", pulses, busy);
        end
        run_op(1'b0, 32'd1000, 32'd9, res, lat, pulses);
        checks++;
        if (res !== {32'd1, 32'd111} || lat != 33 || pulses != 1) begin
            errors++;
            $display("FAIL reset_mid_recover result=%h lat=%0d pulses=%0d expected %h 33 1", res, lat, pulses, {32'd1, 32'd111});
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] r1, r2;
        int l1, l2, pulses;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b1; a = 32'hFFFFFF9C; b = 32'd7;
        @(posedge clk);
        #1;
        signed_div = 1'b0; a = 32'hDEADBEEF; b = 32'd1234;
        l1 = 0; l2 = 0; pulses = 0; r1 = '0; r2 = '0;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                if (l1 == 0) begin
                    l1 = k; r1 = result;
                end else if (l2 == 0) begin
                    l2 = k; r2 = result;
                    start = 1'b0;
                end
            end
            if (k == 80) start = 1'b0;
        end
        checks++;
        if (l1 != 33 || l2 != 67 || pulses != 2) begin
            errors++;
            $display("FAIL b2b_timing first=%0d second=%0d pulses=%0d expected 33 67 2", l1, l2, pulses);
        end
        checks++;
        if (r1 !== ref_div(1'b1, 32'hFFFFFF9C, 32'd7) || r2 !== ref_div(1'b0, 32'hDEADBEEF, 32'd1234)) begin
            errors++;
            $display("FAIL b2b_results r1=%h r2=%h expected %h %h", r1, r2,
                     ref_div(1'b1, 32'hFFFFFF9C, 32'd7), ref_div(1'b0, 32'hDEADBEEF, 32'd1234));
        end
    endtask

`ifdef DIV_FLUSH_EN
    task automatic test_flush;
        logic [63:0] prior;
        int lat, pulses;
        run_op(1'b0, 32'd100, 32'd7, prior, lat, pulses);
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd999; b = 32'd10;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 20) flush = 1'b1;
            if (k == 21) begin
                flush = 1'b0;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_idle busy=%b expected 0", busy);
                end
            end
            if (valid) pulses++;
        end
        checks++;
        if (pulses != 0 || result !== prior) begin
            errors++;
            $display("FAIL flush_hold pulses=%0d result=%h expected 0 %h", pulses, result, prior);
        end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; a = 32'd5; b = 32'd1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority busy=%b expected 0", busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
`ifdef DIV_FLUSH_EN
        test_flush();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have clk, input, 1, single rising-edge clock.
REQ-002 SHALL have resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have start, input, 1, division request, sampled only in IDLE.
REQ-004 SHALL have signed_div, input, 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-005 SHALL have a, input, 32, dividend, sampled with start.
REQ-006 SHALL have b, input, 32, divisor, sampled with start.
REQ-007 SHALL have flush, input, 1, abort request; present only under DIV_FLUSH_EN.
REQ-008 SHALL have busy, output, 1, high in CALC and DONE.
REQ-009 SHALL have valid, output, 1, one-cycle result strobe.
REQ-010 SHALL have result, output, 64, hilo format {remainder[31:0], quotient[31:0]}.

Function
REQ-011 SHALL implement states IDLE, CALC, DONE.
REQ-012 SHALL treat start=1 at an IDLE edge as acceptance: latch |a|, |b| (or raw values if unsigned), both sign bits and signed_div; clear the iteration counter; go to CALC.
REQ-013 SHALL perform one restoring shift-subtract step per CALC edge, for 32 steps.
REQ-014 SHALL, on the 32nd step edge, register the sign-corrected result and enter DONE.
REQ-015 SHALL assert valid only in DONE; DONE lasts exactly one cycle and then returns to IDLE. If start is accepted at edge N, valid is sampled high at edge N+33.
REQ-016 SHALL hold result at its last value outside DONE; result changes only at the edge entering DONE.
REQ-017 SHALL ignore start in CALC and DONE, with no queuing.
REQ-018 SHALL apply the signed rule: quotient negated when sign(a) XOR sign(b), and remainder takes the sign of a.
REQ-019 SHALL, for b == 0 (either signedness), produce result = {a, 32'hFFFFFFFF} with normal latency.
REQ-020 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce quotient 0x80000000 and remainder 0 with no exception output.
REQ-021 SHALL allow back-to-back operation: start accepted in the IDLE cycle directly after DONE.

Reset
REQ-022 SHALL, while resetn=0, force IDLE, busy=0, valid=0, result=64'd0, and counter=0, irrespective of clk.
REQ-023 SHALL, on reset mid-operation, discard the operation with no valid pulse.

Configuration
REQ-024 SHALL, with DIV_FLUSH_EN defined, have a flush port: flush=1 at any edge in CALC or DONE returns to IDLE next state, suppresses valid, and leaves result unchanged.
REQ-025 SHALL, with DIV_FLUSH_EN defined, give flush priority when flush=1 and start=1 in IDLE: start is not accepted.
REQ-026 SHALL, without DIV_FLUSH_EN, omit the flush port; every accepted operation completes.

Structure
REQ-027 SHALL place in the shared CPU package: the state enum (IDLE/CALC/DONE), DIV_WIDTH=32, DIV_ITERS=32.
REQ-028 SHALL use one combinational sub-module, div_step: one restoring step taking partial remainder, quotient and divisor, returning the next partial remainder and quotient.

Verification
REQ-029 SHALL cover: unsigned 100/7 -> valid at N+33, result = {32'd2, 32'd14}.
REQ-030 SHALL cover: signed -7/2 -> result = {32'hFFFFFFFF, 32'hFFFFFFFD}; signed 7/-2 -> {32'd1, 32'hFFFFFFFD}.
REQ-031 SHALL cover: a=0x12345678, b=0 (signed and unsigned) -> result = {32'h12345678, 32'hFFFFFFFF}; signed 0x80000000/-1 -> {32'd0, 32'h80000000}.
REQ-032 SHALL cover: start pulsed at N+5 with new operands during CALC -> ignored; first result unchanged; single valid.
REQ-033 SHALL cover: resetn low at N+10 -> busy=0, result=0, no valid; next start completes normally.
REQ-034 SHALL cover, under DIV_FLUSH_EN: flush at N+20 -> IDLE at N+21, no valid, result holds the prior value; back-to-back starts give valid at N+33 and N+67.
